// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read-channel arbiter: round-robin AR grant, one burst outstanding,
// grant held until the rlast handshake, R beats routed to the granted client only.
//
// state | meaning
// IDLE  | no grant; pick the next requester starting at rr_ptr
// ADDR  | granted client's AR presented downstream, waiting for m_arready
// DATA  | R beats routed to the granted client until rlast is accepted
module axi_rd_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int DATA_WIDTH  = 128,
    parameter int ID_WIDTH    = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0] s_arid,
    input  logic [NUM_MASTERS*32-1:0]     s_araddr,
    input  logic [NUM_MASTERS*8-1:0]      s_arlen,
    input  logic [NUM_MASTERS*3-1:0]      s_arsize,
    input  logic [NUM_MASTERS*2-1:0]      s_arburst,
    input  logic [NUM_MASTERS-1:0]        s_arvalid,
    output logic [NUM_MASTERS-1:0]        s_arready,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [ID_WIDTH-1:0]           s_rid,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    output logic [NUM_MASTERS-1:0]        s_rvalid,
    input  logic [NUM_MASTERS-1:0]        s_rready,
    output logic [ID_WIDTH-1:0]           m_arid,
    output logic [31:0]                   m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    output logic [1:0]                    m_arlock,
    output logic [3:0]                    m_arcache,
    output logic [2:0]                    m_arprot,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [ID_WIDTH-1:0]           m_rid,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] next_grant;
    logic          req_found;

    // Round-robin search: offset k from rr_ptr maps to client (rr_ptr + k) mod N.
    always_comb begin
        int idx;
        idx        = 0;
        req_found  = 1'b0;
        next_grant = rr_ptr;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!req_found && idx == i && s_arvalid[i]) begin
                    req_found  = 1'b1;
                    next_grant = GW'(i);
                end
            end
        end
    end

    always_comb begin
        m_arid    = s_arid[ID_WIDTH-1:0];
        m_araddr  = s_araddr[31:0];
        m_arlen   = s_arlen[7:0];
        m_arsize  = s_arsize[2:0];
        m_arburst = s_arburst[1:0];
        m_rready  = 1'b0;
        s_arready = '0;
        s_rvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant == GW'(i)) begin
                m_arid       = s_arid[i*ID_WIDTH +: ID_WIDTH];
                m_araddr     = s_araddr[i*32 +: 32];
                m_arlen      = s_arlen[i*8 +: 8];
                m_arsize     = s_arsize[i*3 +: 3];
                m_arburst    = s_arburst[i*2 +: 2];
                s_arready[i] = (state == ADDR) && m_arready;
                s_rvalid[i]  = (state == DATA) && m_rvalid;
                m_rready     = (state == DATA) && s_rready[i];
            end
        end
    end

    assign m_arvalid = (state == ADDR);
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;

    assign s_rdata = m_rdata;
    assign s_rid   = m_rid;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_found) begin
                        grant <= next_grant;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) state <= DATA;
                end
                DATA: begin
                    if (m_rvalid && m_rready && m_rlast) begin
                        state  <= IDLE;
                        rr_ptr <= (grant == GW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: table of AR/R transactions on a 3-client
// instance plus hand sequences for async reset and a 1-client narrow instance.
module tb_axi_rd_arbiter;

    logic aclk;
    logic aresetn;

    logic [11:0]  s_arid;
    logic [95:0]  s_araddr;
    logic [23:0]  s_arlen;
    logic [8:0]   s_arsize;
    logic [5:0]   s_arburst;
    logic [2:0]   s_arvalid;
    logic [2:0]   s_arready;
    logic [127:0] s_rdata;
    logic [3:0]   s_rid;
    logic [1:0]   s_rresp;
    logic         s_rlast;
    logic [2:0]   s_rvalid;
    logic [2:0]   s_rready;
    logic [3:0]   m_arid;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;
    logic [1:0]   m_arburst;
    logic [1:0]   m_arlock;
    logic [3:0]   m_arcache;
    logic [2:0]   m_arprot;
    logic         m_arvalid;
    logic         m_arready;
    logic [3:0]   m_rid;
    logic [127:0] m_rdata;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         m_rvalid;
    logic         m_rready;

    logic [1:0]  s1_arid;
    logic [31:0] s1_araddr;
    logic [7:0]  s1_arlen;
    logic [2:0]  s1_arsize;
    logic [1:0]  s1_arburst;
    logic [0:0]  s1_arvalid;
    logic [0:0]  s1_arready;
    logic [31:0] s1_rdata;
    logic [1:0]  s1_rid;
    logic [1:0]  s1_rresp;
    logic        s1_rlast;
    logic [0:0]  s1_rvalid;
    logic [0:0]  s1_rready;
    logic [1:0]  m1_arid;
    logic [31:0] m1_araddr;
    logic [7:0]  m1_arlen;
    logic [2:0]  m1_arsize;
    logic [1:0]  m1_arburst;
    logic [1:0]  m1_arlock;
    logic [3:0]  m1_arcache;
    logic [2:0]  m1_arprot;
    logic        m1_arvalid;
    logic        m1_arready;
    logic [1:0]  m1_rid;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_rlast;
    logic        m1_rvalid;
    logic        m1_rready;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rid(s_rid), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    axi_rd_arbiter #(.NUM_MASTERS(1), .DATA_WIDTH(32), .ID_WIDTH(2)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_arid(s1_arid), .s_araddr(s1_araddr), .s_arlen(s1_arlen), .s_arsize(s1_arsize),
        .s_arburst(s1_arburst), .s_arvalid(s1_arvalid), .s_arready(s1_arready),
        .s_rdata(s1_rdata), .s_rid(s1_rid), .s_rresp(s1_rresp), .s_rlast(s1_rlast),
        .s_rvalid(s1_rvalid), .s_rready(s1_rready),
        .m_arid(m1_arid), .m_araddr(m1_araddr), .m_arlen(m1_arlen), .m_arsize(m1_arsize),
        .m_arburst(m1_arburst), .m_arlock(m1_arlock), .m_arcache(m1_arcache), .m_arprot(m1_arprot),
        .m_arvalid(m1_arvalid), .m_arready(m1_arready),
        .m_rid(m1_rid), .m_rdata(m1_rdata), .m_rresp(m1_rresp), .m_rlast(m1_rlast),
        .m_rvalid(m1_rvalid), .m_rready(m1_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [2:0]  mask;
        logic [7:0]  len;
        logic [31:0] base;
        int          stall;
        bit          toggle;
        logic [2:0]  late;
        int          exp_g;
    } vec_t;

    vec_t vecs[12];
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Client i drives address base + i*0x1000, id i+5, size i+1, burst i.
    task automatic set_fields(input logic [31:0] base, input logic [7:0] len);
        for (int i = 0; i < 3; i++) begin
            s_araddr[i*32 +: 32] = base + 32'(i) * 32'h1000;
            s_arid[i*4 +: 4]     = 4'(i + 5);
            s_arlen[i*8 +: 8]    = len;
            s_arsize[i*3 +: 3]   = 3'(i + 1);
            s_arburst[i*2 +: 2]  = 2'(i);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          g;
        int          beats;
        int          cyc;
        bit          phase;
        bit          acc;
        logic [2:0]  oh;
        logic [31:0] exp_addr;
        logic [127:0] beat_data;
        g        = v.exp_g;
        oh       = 3'(1 << g);
        exp_addr = v.base + 32'(g) * 32'h1000;
        set_fields(v.base, v.len);
        s_arvalid = v.mask;
        m_arready = 1'b0;
        @(negedge aclk);
        chk("ar_latency", 128'(m_arvalid), 128'(1'b1));
        chk("ar_addr", 128'(m_araddr), 128'(exp_addr));
        chk("ar_id", 128'(m_arid), 128'(4'(g + 5)));
        chk("ar_len", 128'(m_arlen), 128'(v.len));
        chk("ar_size_burst", 128'({m_arsize, m_arburst}), 128'({3'(g + 1), 2'(g)}));
        for (int s = 0; s < v.stall; s++) begin
            chk("ar_stall_ready", 128'(s_arready), 128'(3'b000));
            chk("ar_stall_addr", 128'(m_araddr), 128'(exp_addr));
            chk("ar_stall_valid", 128'(m_arvalid), 128'(1'b1));
            @(negedge aclk);
        end
        m_arready = 1'b1;
        #1;
        chk("ar_ready_onehot", 128'(s_arready), 128'(oh));
        @(negedge aclk);
        m_arready    = 1'b0;
        s_arvalid[g] = 1'b0;
        chk("ar_done_valid", 128'(m_arvalid), 128'(1'b0));
        beats = 0;
        cyc   = 0;
        phase = 1'b0;
        while (beats <= int'(v.len) && cyc < 200) begin
            beat_data = {v.base, 32'(beats), 64'h0123_4567_89ab_cdef};
            acc       = v.toggle ? phase : 1'b1;
            phase     = ~phase;
            m_rvalid  = 1'b1;
            m_rdata   = beat_data;
            m_rid     = 4'hA;
            m_rresp   = 2'(beats);
            m_rlast   = (beats == int'(v.len));
            s_rready  = acc ? oh : 3'b000;
            if (beats == 1) s_arvalid = s_arvalid | v.late;
            #1;
            chk("r_valid_route", 128'(s_rvalid), 128'(oh));
            chk("r_ready_mirror", 128'(m_rready), 128'(acc));
            chk("r_data", s_rdata, beat_data);
            chk("r_id_resp_last", 128'({s_rid, s_rresp, s_rlast}),
                128'({4'hA, 2'(beats), beats == int'(v.len)}));
            chk("r_no_ar", 128'({m_arvalid, s_arready}), 128'(4'b0000));
            if (acc) beats++;
            @(negedge aclk);
            cyc++;
        end
        chk("r_beat_count", 128'(beats), 128'(int'(v.len) + 1));
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        s_rready = 3'b000;
        #1;
        chk("idle_outputs", 128'({m_arvalid, m_rready, s_rvalid, s_arready}), 128'(8'h00));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //            mask    len   base          stall tog late   grant
        vecs[0]  = '{3'b111, 8'd0, 32'h8000_0000, 0, 1'b0, 3'b000, 0};
        vecs[1]  = '{3'b111, 8'd0, 32'h8010_0000, 0, 1'b0, 3'b000, 1};
        vecs[2]  = '{3'b111, 8'd0, 32'h8020_0000, 0, 1'b0, 3'b000, 2};
        vecs[3]  = '{3'b111, 8'd0, 32'h8030_0000, 0, 1'b0, 3'b000, 0};
        vecs[4]  = '{3'b010, 8'd3, 32'h1BFF_F000, 0, 1'b0, 3'b000, 1};
        vecs[5]  = '{3'b011, 8'd1, 32'hA000_0000, 0, 1'b0, 3'b100, 0};
        vecs[6]  = '{3'b100, 8'd0, 32'hA100_0000, 0, 1'b0, 3'b000, 2};
        vecs[7]  = '{3'b101, 8'd7, 32'hB000_0000, 5, 1'b1, 3'b000, 0};
        vecs[8]  = '{3'b101, 8'd0, 32'hB100_0000, 0, 1'b0, 3'b000, 2};
        vecs[9]  = '{3'b110, 8'd2, 32'hC000_0000, 0, 1'b0, 3'b000, 1};
        vecs[10] = '{3'b001, 8'd0, 32'hD000_0000, 0, 1'b0, 3'b000, 0};
        vecs[11] = '{3'b011, 8'd0, 32'hE000_0000, 0, 1'b0, 3'b000, 0};

        aresetn   = 1'b0;
        set_fields(32'h0, 8'd0);
        s_arvalid = 3'b111;
        s_rready  = 3'b111;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        m_rid     = 4'h0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        s1_arid = 2'b10; s1_araddr = 32'h4000_0000; s1_arlen = 8'd7;
        s1_arsize = 3'd2; s1_arburst = 2'b01; s1_arvalid = 1'b0; s1_rready = 1'b0;
        m1_arready = 1'b0; m1_rid = 2'b10; m1_rdata = '0; m1_rresp = 2'b00;
        m1_rlast = 1'b0; m1_rvalid = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        chk("reset_ar", 128'({m_arvalid, s_arready}), 128'(4'b0000));
        chk("reset_r", 128'({m_rready, s_rvalid}), 128'(4'b0000));
        chk("const_ar", 128'({m_arlock, m_arcache, m_arprot}), 128'(9'h000));
        s_arvalid = 3'b000;
        s_rready  = 3'b000;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        for (int v = 0; v < 11; v++) run_vec(vecs[v]);

        // Async reset during beat 2 of a 4-beat burst from client 1.
        set_fields(32'h9000_0000, 8'd3);
        s_arvalid = 3'b010;
        @(negedge aclk);
        chk("rst_seq_ar", 128'({m_arvalid, m_araddr}), 128'({1'b1, 32'h9000_1000}));
        m_arready = 1'b1;
        #1;
        chk("rst_seq_arready", 128'(s_arready), 128'(3'b010));
        @(negedge aclk);
        m_arready = 1'b0;
        s_arvalid = 3'b000;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b0;
        m_rdata   = 128'h1;
        s_rready  = 3'b010;
        @(negedge aclk);
        m_rdata = 128'h2;
        #1;
        chk("rst_seq_beat2", 128'(s_rvalid), 128'(3'b010));
        #1;
        aresetn = 1'b0;
        #1;
        chk("rst_async_outs", 128'({m_arvalid, m_rready, s_rvalid}), 128'(5'b00000));
        @(negedge aclk);
        m_rvalid = 1'b0;
        s_rready = 3'b000;
        aresetn  = 1'b1;
        @(negedge aclk);
        run_vec(vecs[11]);

        // Single-client narrow instance: back-to-back 8-beat bursts with the idle bubble.
        s1_arvalid = 1'b1;
        for (int t = 0; t < 2; t++) begin
            @(negedge aclk);
            chk("n1_ar_latency", 128'(m1_arvalid), 128'(1'b1));
            chk("n1_ar_fields", 128'({m1_araddr, m1_arid, m1_arlen}), 128'({32'h4000_0000, 2'b10, 8'd7}));
            m1_arready = 1'b1;
            #1;
            chk("n1_arready", 128'(s1_arready), 128'(1'b1));
            @(negedge aclk);
            m1_arready = 1'b0;
            for (int b = 0; b < 8; b++) begin
                m1_rvalid = 1'b1;
                m1_rdata  = 32'hC0DE_0000 + 32'(b);
                m1_rlast  = (b == 7);
                s1_rready = 1'b1;
                #1;
                chk("n1_r_route", 128'({s1_rvalid, m1_rready, s1_rlast}), 128'({1'b1, 1'b1, b == 7}));
                chk("n1_r_data", 128'(s1_rdata), 128'(32'hC0DE_0000 + 32'(b)));
                chk("n1_no_x", 128'($isunknown({s1_arready, s1_rdata, s1_rid, s1_rresp, s1_rlast,
                    s1_rvalid, m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock,
                    m1_arcache, m1_arprot, m1_arvalid, m1_rready})), 128'(1'b0));
                @(negedge aclk);
            end
            m1_rvalid = 1'b0;
            m1_rlast  = 1'b0;
            s1_rready = 1'b0;
            #1;
            chk("n1_bubble", 128'({m1_arvalid, s1_arready, s1_rvalid}), 128'(3'b000));
        end
        s1_arvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
